fb_pixel_writer: RTL

Framebuffer write stage downstream of the line/triangle rasteriser. Accepts the rasteriser's pixel stream (X, Y, 12-bit colour) through a valid/ready handshake, buffers it in a small FIFO, and converts each pixel to a linear framebuffer address with one memory write per cycle. Also performs a full-screen clear to a programmable colour, ordered after every pixel already accepted. Sits between the rasteriser and the single-port framebuffer RAM that the scan-out logic reads.

---
 rtl/fb_pixel_writer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - pixel FIFO, address stage and full-screen clear for the framebuffer
// Optional out-of-range drop counter enabled by defining FBW_DROP_COUNT_EN.
`timescale 1ns/1ps
module fb_pixel_writer #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        Mreset,
   input  logic        pix_valid,
   input  logic [9:0]  pix_x,
   input  logic [8:0]  pix_y,
   input  logic [11:0] pix_rgb,
   output logic        pix_ready,
   input  logic        clr_start,
   input  logic [11:0] clr_color,
   output logic        clr_busy,
   output logic        fb_we,
   output logic [18:0] fb_addr,
   output logic [11:0] fb_wdata,
   output logic [15:0] drop_cnt
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]  FULL_CNT  = (PW+1)'(FIFO_DEPTH);
   localparam logic [18:0]  LAST_ADDR = 19'(H_RES * V_RES - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
   state_t state, state_next;

   logic [30:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count, count_next;
   logic          push, pop, clr_accept;

   logic          s_valid;
   logic [9:0]    s_x;
   logic [8:0]    s_y;
   logic [11:0]   s_rgb;
   logic          in_range;
   logic [18:0]   pix_addr;

   logic [11:0]   clr_color_q;
   logic [18:0]   clr_addr;

   assign push       = pix_valid & pix_ready;
   assign pop        = (count != '0) && (state != CLEAR);
   assign clr_accept = clr_start & ~clr_busy & (state == IDLE);
   assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (clr_accept) state_next = DRAIN;
         // Empty FIFO means the stage's last pixel is written on this same edge.
         DRAIN: if (count == '0) state_next = CLEAR;
         CLEAR: if (clr_addr == LAST_ADDR) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_range = (32'(s_x) < H_RES) && (32'(s_y) < V_RES);
      if (H_RES == 640)
         pix_addr = ({10'b0, s_y} << 9) + ({10'b0, s_y} << 7) + {9'b0, s_x};
      else
         pix_addr = 19'(32'(s_y) * H_RES) + {9'b0, s_x};
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {pix_x, pix_y, pix_rgb};
   end

   always_ff @(posedge clk) begin
      if (Mreset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         pix_ready   <= 1'b0;
         clr_busy    <= 1'b0;
         clr_color_q <= '0;
         clr_addr    <= '0;
         s_valid     <= 1'b0;
         s_x         <= '0;
         s_y         <= '0;
         s_rgb       <= '0;
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         fb_wdata    <= '0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         pix_ready <= (state_next == IDLE) && (count_next != FULL_CNT);
         clr_busy  <= (state_next != IDLE);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         s_valid <= pop;
         if (pop) begin
            {s_x, s_y, s_rgb} <= fifo_mem[rd_ptr];
            rd_ptr            <= rd_ptr + PW'(1);
         end
         if (clr_accept) clr_color_q <= clr_color;
         fb_we <= 1'b0;
         if (state == CLEAR) begin
            fb_we    <= 1'b1;
            fb_addr  <= clr_addr;
            fb_wdata <= clr_color_q;
            clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 19'd1;
         end else if (s_valid && in_range) begin
            fb_we    <= 1'b1;
            fb_addr  <= pix_addr;
            fb_wdata <= s_rgb;
         end
      end
   end

`ifdef FBW_DROP_COUNT_EN
   logic [15:0] drop_q;
   always_ff @(posedge clk) begin
      if (Mreset)
         drop_q <= '0;
      else if (s_valid && !in_range && drop_q != 16'hFFFF)
         drop_q <= drop_q + 16'd1;
   end
   assign drop_cnt = drop_q;
`else
   assign drop_cnt = '0;
`endif

endmodule
